// File: rtl/decode_pkg.sv
// decode_pkg: shared types and encodings for the RV32I decode stage.
// Holds the control bundle struct, the opcode map and the ImmSrc /
// LoadSize / MemWrite field encodings used by ctrl_decode and its users.
package decode_pkg;

  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_src;
    logic [1:0] alua_src;
    logic       alub_src;
    logic [1:0] mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
    logic [2:0] load_size;
    logic       pc_target_alu_src;
    logic       mul_div;
  } ctrl_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_J     = 3'b011;
  localparam logic [2:0] IMM_ISHFT = 3'b100;
  localparam logic [2:0] IMM_U     = 3'b101;

  localparam logic [2:0] LS_W  = 3'b000;
  localparam logic [2:0] LS_B  = 3'b001;
  localparam logic [2:0] LS_BU = 3'b010;
  localparam logic [2:0] LS_H  = 3'b011;
  localparam logic [2:0] LS_HU = 3'b100;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_SW   = 2'b01;
  localparam logic [1:0] MW_SH   = 2'b10;
  localparam logic [1:0] MW_SB   = 2'b11;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshake bundle of the
// decode stage. The slave modport is the decode stage itself; the master
// modport is the surrounding pipeline (fetch driver + execute consumer).
interface decode_stage_if #(
  parameter int XLEN = 32
);
  import decode_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  ctrl_t           out_ctrl;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic            out_funct7b5;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_ctrl, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7b5, out_instr, out_pc, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_ctrl, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7b5, out_instr, out_pc, out_illegal
  );

endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational RV32I main decoder, instruction word to
// control bundle plus illegal flag. Macro RV32M_EN enables decoding of
// the M extension (R-type funct7=0000001 sets mul_div); without it those
// encodings are reported illegal.
module ctrl_decode
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Opcode/funct3 to control fields; an illegal word forces all controls to 0
  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    if (instr == 32'h0000_0000) begin
      illegal = 1'b0;
    end else if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode)
        OP_LOAD: begin
          ctrl.reg_write  = 1'b1;
          ctrl.alub_src   = 1'b1;
          ctrl.result_src = 2'b01;
          case (funct3)
            3'b000:  ctrl.load_size = LS_B;
            3'b001:  ctrl.load_size = LS_H;
            3'b010:  ctrl.load_size = LS_W;
            3'b100:  ctrl.load_size = LS_BU;
            3'b101:  ctrl.load_size = LS_HU;
            default: illegal = 1'b1;
          endcase
        end
        OP_STORE: begin
          ctrl.imm_src  = IMM_S;
          ctrl.alub_src = 1'b1;
          case (funct3)
            3'b000:  ctrl.mem_write = MW_SB;
            3'b001:  ctrl.mem_write = MW_SH;
            3'b010:  ctrl.mem_write = MW_SW;
            default: illegal = 1'b1;
          endcase
        end
        OP_R: begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = 2'b10;
`ifdef RV32M_EN
          if (funct7 == F7_MULDIV) ctrl.mul_div = 1'b1;
`else
          if (funct7 == F7_MULDIV) illegal = 1'b1;
`endif
        end
        OP_BRANCH: begin
          ctrl.imm_src = IMM_B;
          ctrl.branch  = 1'b1;
          ctrl.alu_op  = 2'b01;
        end
        OP_IMM: begin
          ctrl.reg_write = 1'b1;
          ctrl.alub_src  = 1'b1;
          ctrl.alu_op    = 2'b10;
          ctrl.imm_src   = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_ISHFT : IMM_I;
        end
        OP_JAL: begin
          ctrl.reg_write  = 1'b1;
          ctrl.imm_src    = IMM_J;
          ctrl.result_src = 2'b10;
          ctrl.jump       = 1'b1;
        end
        OP_LUI: begin
          ctrl.reg_write = 1'b1;
          ctrl.imm_src   = IMM_U;
          ctrl.alua_src  = 2'b01;
          ctrl.alub_src  = 1'b1;
        end
        OP_AUIPC: begin
          ctrl.reg_write = 1'b1;
          ctrl.imm_src   = IMM_U;
          ctrl.alua_src  = 2'b10;
          ctrl.alub_src  = 1'b1;
        end
        OP_JALR: begin
          ctrl.reg_write         = 1'b1;
          ctrl.alub_src          = 1'b1;
          ctrl.result_src        = 2'b10;
          ctrl.jump              = 1'b1;
          ctrl.pc_target_alu_src = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
    if (illegal) ctrl = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage. Instructions are decoded on
// entry (ctrl_decode) and stored with their PC in a circular output buffer
// of BUF_DEPTH entries, decoupling fetch from execute. Optional macro
// RV32M_EN (consumed by ctrl_decode) enables M-extension decoding.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2
) (
  input logic           clk,
  input logic           reset,
  input logic           flush,
  decode_stage_if.slave bus
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  // Entry side: decode result of the presented instruction
  ctrl_t ctrl_p0;
  logic  illegal_p0;

  ctrl_decode u_ctrl_decode (
    .instr   (bus.in_instr),
    .ctrl    (ctrl_p0),
    .illegal (illegal_p0)
  );

  // Buffer storage and bookkeeping
  ctrl_t           ctrl_mem  [BUF_DEPTH];
  logic            ill_mem   [BUF_DEPTH];
  logic [31:0]     instr_mem [BUF_DEPTH];
  logic [XLEN-1:0] pc_mem    [BUF_DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             vld_p1;
  logic             push;
  logic             pop;

  // Last head entry shown while the buffer is empty
  ctrl_t           hold_ctrl;
  logic            hold_ill;
  logic [31:0]     hold_instr;
  logic [XLEN-1:0] hold_pc;

  ctrl_t           head_ctrl;
  logic            head_ill;
  logic [31:0]     head_instr;
  logic [XLEN-1:0] head_pc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign vld_p1       = (count != '0);
  assign bus.in_ready = (count < CNT_W'(BUF_DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = vld_p1 && bus.out_ready;

  // Pointer and occupancy update: reset > flush > push/pop
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry write at the tail; a push coinciding with flush is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        ctrl_mem[i]  <= '0;
        ill_mem[i]   <= 1'b0;
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (push && !flush) begin
      ctrl_mem[tail]  <= ctrl_p0;
      ill_mem[tail]   <= illegal_p0;
      instr_mem[tail] <= bus.in_instr;
      pc_mem[tail]    <= bus.in_pc;
    end
  end

  assign head_ctrl  = ctrl_mem[head];
  assign head_ill   = ill_mem[head];
  assign head_instr = instr_mem[head];
  assign head_pc    = pc_mem[head];

  // Track the currently presented entry so outputs freeze once it drains
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_ctrl  <= '0;
      hold_ill   <= 1'b0;
      hold_instr <= '0;
      hold_pc    <= '0;
    end else if (vld_p1) begin
      hold_ctrl  <= head_ctrl;
      hold_ill   <= head_ill;
      hold_instr <= head_instr;
      hold_pc    <= head_pc;
    end
  end

  // Head entry out
  logic [31:0] out_word;

  assign out_word         = vld_p1 ? head_instr : hold_instr;
  assign bus.out_valid    = vld_p1;
  assign bus.out_ctrl     = vld_p1 ? head_ctrl : hold_ctrl;
  assign bus.out_illegal  = vld_p1 ? head_ill  : hold_ill;
  assign bus.out_pc       = vld_p1 ? head_pc   : hold_pc;
  assign bus.out_instr    = out_word;
  assign bus.out_rd       = out_word[11:7];
  assign bus.out_rs1      = out_word[19:15];
  assign bus.out_rs2      = out_word[24:20];
  assign bus.out_funct3   = out_word[14:12];
  assign bus.out_funct7b5 = out_word[30];

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage for the RV32I core. It accepts a fetched instruction and PC over a valid/ready handshake and produces the full control bundle, register indices and an illegal-instruction flag. Results go into an output buffer of configurable depth, so fetch and execute are decoupled. It sits between the fetch stage and the register-file/execute stage and replaces the purely combinational main decoder.

## Interface
Parameters:
- XLEN, 32: width of the PC field carried with each instruction.
- BUF_DEPTH, 2: number of output buffer entries; a power of two, at least 1.

Ports:
- clk  in  1  the single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush (branch redirect or trap).
- in_valid  in  1  the fetch stage presents an instruction.
- in_ready  out  1  the stage can accept an instruction this cycle.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  the head buffer entry is valid.
- out_ready  in  1  the downstream stage consumes the head entry.
- out_ctrl  out  ctrl_t  {RegWrite, ImmSrc[2:0], ALUASrc[1:0], ALUBSrc, MemWrite[1:0], ResultSrc[1:0], Branch, ALUOp[1:0], Jump, LoadSize[2:0], PCTargetALUSrc, MulDiv}.
- out_rd, out_rs1, out_rs2  out  5 each  register indices from instr[11:7], [19:15] and [24:20].
- out_funct3  out  3  instr[14:12].
- out_funct7b5  out  1  instr[30].
- out_instr  out  32  the instruction word, passed through.
- out_pc  out  XLEN  the PC, passed through.
- out_illegal  out  1  the instruction is not decodable.

## Operation
- Encodings:
  - ImmSrc: 000 = I, 001 = S, 010 = B, 011 = J, 100 = I-shift, 101 = U.
  - LoadSize: 000 = w, 001 = b, 010 = bu, 011 = h, 100 = hu.
  - MemWrite: 00 = none, 01 = sw, 10 = sh, 11 = sb.
- Opcodes decoded, with their control fields:
  - Load (0000011): RegWrite=1, ALUBSrc=1, ResultSrc=01; funct3 000/001/010/100/101 select LoadSize.
  - Store (0100011): ImmSrc=001, ALUBSrc=1; funct3 000/001/010 select MemWrite.
  - R-type (0110011): RegWrite=1, ALUOp=10.
  - Branch (1100011): ImmSrc=010, Branch=1, ALUOp=01.
  - OP-IMM (0010011): RegWrite=1, ALUBSrc=1, ALUOp=10; ImmSrc=100 when funct3 is 001 or 101, otherwise 000.
  - JAL (1101111): RegWrite=1, ImmSrc=011, ResultSrc=10, Jump=1.
  - LUI (0110111): RegWrite=1, ImmSrc=101, ALUASrc=01, ALUBSrc=1.
  - AUIPC (0010111): as LUI but ALUASrc=10.
  - JALR (1100111): RegWrite=1, ALUBSrc=1, ResultSrc=10, Jump=1, PCTargetALUSrc=1.
- in_instr == 0x00000000 is a bubble: all controls 0 and out_illegal=0.
- An instruction is illegal when instr[1:0] != 11, the opcode is not listed above, or funct3 is unlisted for load or store. An illegal instruction gets all controls 0 (no register write, memory write or jump) and out_illegal=1. It still occupies a buffer slot.
- Buffer: circular, with head/tail pointers of clog2(BUF_DEPTH) bits that wrap modulo BUF_DEPTH, and a count of clog2(BUF_DEPTH)+1 bits.
- Push when in_valid && in_ready. Pop when out_valid && out_ready. A simultaneous push and pop leaves the count unchanged.
- in_ready = (count < BUF_DEPTH). It is registered-state only, with no combinational path from out_ready. A full buffer stalls fetch even while it is popping.
- All out_* fields come from the head entry. When out_valid=0 they hold their last value.

## Timing
- Latency is 1: an instruction pushed at edge N is visible with out_valid=1 after edge N, provided the buffer was empty.
- Throughput is 1 instruction per cycle when BUF_DEPTH >= 2 and out_ready=1 continuously. With BUF_DEPTH=1 it is 1 instruction per 2 cycles.
- Reset: count=0, head=tail=0, out_valid=0, in_ready=1, and every out_* field is 0. Reset mid-operation discards all entries at that edge.
- flush: at the edge where flush=1, count, head and tail go to 0 and out_valid=0. A push in the same cycle is dropped, as is a pop. in_ready=1 on the next cycle.
- Priority is reset > flush > push/pop.

## Configuration
- RV32M_EN defined: R-type with funct7=0000001 decodes as RegWrite=1, ALUOp=10, MulDiv=1.
- RV32M_EN undefined: the MulDiv field is tied 0, and funct7=0000001 on R-type gives out_illegal=1 with all controls 0.

## Structure
- Package decode_pkg holds:
  - the ctrl_t packed struct;
  - opcode localparams (OP_LOAD, OP_STORE, OP_R, OP_BRANCH, OP_IMM, OP_JAL, OP_LUI, OP_AUIPC, OP_JALR);
  - the ImmSrc, LoadSize and MemWrite encodings.
- Sub-module ctrl_decode is the combinational instr-to-{ctrl_t, illegal} function. decode_stage instantiates it on the input side and stores its result in the buffer.

## Test plan
- Decode lw: push 0x0002A083 → next cycle out_valid=1, RegWrite=1, ImmSrc=000, ALUBSrc=1, ResultSrc=01, LoadSize=000, rd=1, rs1=5, illegal=0.
- Backpressure: BUF_DEPTH=2, out_ready=0, push three instructions on consecutive cycles → in_ready=0 after the second push and the third is held. Raise out_ready → outputs come out in order with no loss or duplication.
- Illegal: push 0xFFFFFFFF → out_illegal=1, all controls 0. Push 0x00000000 → bubble with out_illegal=0.
- Flush: two entries buffered, flush=1 together with in_valid=1 → next cycle out_valid=0 and count 0, and the flushed-cycle instruction never appears.
- M extension: push 0x022081B3 (mul x3,x1,x2) → with RV32M_EN, MulDiv=1, RegWrite=1, rd=3; without it, out_illegal=1.
- Wrap and reset: run 2×BUF_DEPTH+1 push/pop pairs to check that pointer wrap preserves ordering. Assert reset with entries buffered → next cycle out_valid=0, in_ready=1, all out_* fields 0.
